// File: rtl/cgra_rf_pkg.sv
// cgra_rf_pkg: shared types for the CGRA register file.
//   rf_state_e  - init sequencer states (INIT sweep, then RUN)
//   INIT_*      - encodings for the INIT_MODE parameter
// The project-wide sizing defines (PHIT_SIZE, depth_RF, dwidth_RFadd) stay
// as macros; guarded defaults here let the slice build standalone.
`ifndef PHIT_SIZE
`define PHIT_SIZE 16
`endif
`ifndef depth_RF
`define depth_RF 16
`endif
`ifndef dwidth_RFadd
`define dwidth_RFadd 4
`endif

package cgra_rf_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int INIT_ZERO = 0;  // every entry cleared
  localparam int INIT_X10  = 1;  // entry i = i*10, truncated to DWIDTH

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset sweep that writes one entry per cycle.
//   clk, rst_n   - clock / async active-low reset
//   init_we_o    - high while sweeping (storage takes init data, drops user writes)
//   init_addr_o  - entry being written this cycle
//   init_data_o  - INIT_MODE pattern for that entry
//   ready_o      - registered, rises on the edge that writes entry DEPTH-1
module regfile_init_seq
  import cgra_rf_pkg::*;
#(
  parameter int DWIDTH    = `PHIT_SIZE,
  parameter int DEPTH     = `depth_RF,
  parameter int AWIDTH    = `dwidth_RFadd,
  parameter int INIT_MODE = INIT_ZERO
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we_o,
  output logic [AWIDTH-1:0] init_addr_o,
  output logic [DWIDTH-1:0] init_data_o,
  output logic              ready_o
);

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  rf_state_e         state_q;
  logic [AWIDTH-1:0] cnt_q;
  logic              ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN:  ;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign init_we_o   = (state_q == ST_INIT);
  assign init_addr_o = cnt_q;
  // DWIDTH-wide multiply wraps modulo 2^DWIDTH, which is the truncation we want.
  assign init_data_o = (INIT_MODE == INIT_X10) ? DWIDTH'(cnt_q) * DWIDTH'(10) : '0;
  assign ready_o     = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with init sweep, bypass and error flags.
//   clk, rst_n  - clock / async active-low reset (memory itself is not reset)
//   wen         - per write-port enable             [N_WR]
//   wr_addr     - write addresses                   [N_WR][AWIDTH]
//   d_in        - write data                        [N_WR][DWIDTH]
//   rd_addr     - read addresses                    [N_RD][AWIDTH]
//   d_out       - read data (comb or registered)    [N_RD][DWIDTH]
//   ready       - init sweep finished
//   wr_conflict - one-cycle pulse after a same-address dual write
//   addr_err    - one-cycle pulse after any out-of-range access
`ifndef PHIT_SIZE
`define PHIT_SIZE 16
`endif
`ifndef depth_RF
`define depth_RF 16
`endif
`ifndef dwidth_RFadd
`define dwidth_RFadd 4
`endif

module regfile_mp
  import cgra_rf_pkg::*;
#(
  parameter int DWIDTH    = `PHIT_SIZE,
  parameter int DEPTH     = `depth_RF,
  parameter int AWIDTH    = `dwidth_RFadd,
  parameter int N_RD      = 2,
  parameter int N_WR      = 2,
  parameter int RD_LAT    = 0,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = INIT_ZERO
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_WR-1:0]             wen,
  input  logic [N_WR-1:0][AWIDTH-1:0] wr_addr,
  input  logic [N_WR-1:0][DWIDTH-1:0] d_in,
  input  logic [N_RD-1:0][AWIDTH-1:0] rd_addr,
  output logic [N_RD-1:0][DWIDTH-1:0] d_out,
  output logic                        ready,
  output logic                        wr_conflict,
  output logic                        addr_err
);

  // One extra bit so DEPTH == 2**AWIDTH still compares correctly.
  localparam logic [AWIDTH:0] DEPTH_A = (AWIDTH + 1)'(DEPTH);

  logic                        init_we;
  logic [AWIDTH-1:0]           init_addr;
  logic [DWIDTH-1:0]           init_data;
  logic                        run;

  logic [DWIDTH-1:0]           mem_q [DEPTH];
  logic [N_WR-1:0]             wr_oor, wr_ok, wr_eff;
  logic [N_RD-1:0]             rd_oor;
  logic [N_RD-1:0][DWIDTH-1:0] rd_val;
  logic                        conflict;
  logic                        addr_err_d;
  logic                        wr_conflict_q, addr_err_q;

  regfile_init_seq #(
    .DWIDTH   (DWIDTH),
    .DEPTH    (DEPTH),
    .AWIDTH   (AWIDTH),
    .INIT_MODE(INIT_MODE)
  ) u_init (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_we_o  (init_we),
    .init_addr_o(init_addr),
    .init_data_o(init_data),
    .ready_o    (run)
  );

  always_comb begin
    for (int k = 0; k < N_WR; k++) begin
      wr_oor[k] = ({1'b0, wr_addr[k]} >= DEPTH_A);
      wr_ok[k]  = run & wen[k] & ~wr_oor[k];
    end
    for (int j = 0; j < N_RD; j++) begin
      rd_oor[j] = ({1'b0, rd_addr[j]} >= DEPTH_A);
    end
  end

  generate
    if (N_WR == 2) begin : g_conf
      assign conflict = wr_ok[0] & wr_ok[1] & (wr_addr[0] == wr_addr[1]);
    end else begin : g_noconf
      assign conflict = 1'b0;
    end
  endgenerate

  // Port 0 wins a same-address collision; port 1 is squashed so it neither
  // commits nor forwards.
  always_comb begin
    wr_eff = wr_ok;
    if (conflict) wr_eff[N_WR-1] = 1'b0;
  end

  always_comb begin
    addr_err_d = run & ((|(wen & wr_oor)) | (|rd_oor));
  end

  // Storage: no reset, rebuilt only by the init sweep.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (wr_eff[k]) mem_q[wr_addr[k]] <= d_in[k];
      end
    end
  end

  // Read path: zero while sweeping or out of range, then same-cycle forward.
  always_comb begin
    rd_val = '0;
    for (int j = 0; j < N_RD; j++) begin
      if (run && !rd_oor[j]) rd_val[j] = mem_q[rd_addr[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < N_WR; k++) begin
          if (wr_eff[k] && (wr_addr[k] == rd_addr[j])) rd_val[j] = d_in[k];
        end
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_rd_reg
      logic [N_RD-1:0][DWIDTH-1:0] d_out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_out_q <= '0;
        else        d_out_q <= rd_val;
      end
      assign d_out = d_out_q;
    end else begin : g_rd_comb
      assign d_out = rd_val;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      wr_conflict_q <= conflict;
      addr_err_q    <= addr_err_d;
    end
  end

  assign ready       = run;
  assign wr_conflict = wr_conflict_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: four regfile_mp variants share one stimulus stream.
//   u_a: DEPTH16 x10-init, comb read, bypass
//   u_b: DEPTH16 x10-init, comb read, no bypass
//   u_c: DEPTH16 x10-init, registered read, bypass
//   u_d: DEPTH12 zero-init, comb read, bypass
module tb_regfile_mp;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         wen;
  logic [1:0][AW-1:0] wr_addr;
  logic [1:0][DW-1:0] d_in;
  logic [1:0][AW-1:0] rd_addr;

  logic [1:0][DW-1:0] dout_a, dout_b, dout_c, dout_d;
  logic rdy_a, rdy_b, rdy_c, rdy_d;
  logic conf_a, conf_b, conf_c, conf_d;
  logic aerr_a, aerr_b, aerr_c, aerr_d;

  regfile_mp #(.DWIDTH(DW), .DEPTH(16), .AWIDTH(AW), .N_RD(2), .N_WR(2),
               .RD_LAT(0), .BYPASS(1), .INIT_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(dout_a), .ready(rdy_a),
    .wr_conflict(conf_a), .addr_err(aerr_a));

  regfile_mp #(.DWIDTH(DW), .DEPTH(16), .AWIDTH(AW), .N_RD(2), .N_WR(2),
               .RD_LAT(0), .BYPASS(0), .INIT_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(dout_b), .ready(rdy_b),
    .wr_conflict(conf_b), .addr_err(aerr_b));

  regfile_mp #(.DWIDTH(DW), .DEPTH(16), .AWIDTH(AW), .N_RD(2), .N_WR(2),
               .RD_LAT(1), .BYPASS(1), .INIT_MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(dout_c), .ready(rdy_c),
    .wr_conflict(conf_c), .addr_err(aerr_c));

  regfile_mp #(.DWIDTH(DW), .DEPTH(12), .AWIDTH(AW), .N_RD(2), .N_WR(2),
               .RD_LAT(0), .BYPASS(1), .INIT_MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(dout_d), .ready(rdy_d),
    .wr_conflict(conf_d), .addr_err(aerr_d));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until u_a is ready (bounded); optionally pokes a user write
  // to entry 0 during the sweep, which must be dropped.
  task automatic wait_ready(input bit poke, output int na, output int nd);
    na = 0;
    nd = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rdy_d && nd == 0) nd = n;
      if (rdy_a) begin
        na = n;
        break;
      end
      if (poke && n <= 10) begin
        wen = 2'b01; wr_addr[0] = '0; d_in[0] = 16'hFFFF;
      end else begin
        wen = 2'b00;
      end
    end
    wen = 2'b00;
  endtask

  int na, nd;

  initial begin
    wen = '0; wr_addr = '0; d_in = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_ready",    rdy_a,     0);
    chk("rst_conflict", conf_a,    0);
    chk("rst_addr_err", aerr_a,    0);
    chk("rst_dout_reg", dout_c[0], 0);
    chk("init_dout0",   dout_a[0], 0);

    rst_n = 1'b1;
    wait_ready(1'b1, na, nd);
    chk("init_lat16", na, 16);
    chk("init_lat12", nd, 12);

    rd_addr[0] = 4'd5; rd_addr[1] = 4'd15; #1;
    chk("init_rd5",      dout_a[0], 50);
    chk("init_rd15",     dout_a[1], 150);
    chk("init_rd5_nbyp", dout_b[0], 50);
    chk("oor_rd_zero",   dout_d[1], 0);
    tick();
    chk("lat_init_rd5",  dout_c[0], 50);
    chk("oor_rd_err",    aerr_d,    1);
    chk("inrange_noerr", aerr_a,    0);
    rd_addr = '0;
    tick();
    chk("oor_rd_err_clr", aerr_d,    0);
    chk("init_drop_wr",   dout_a[0], 0);
    chk("zero_init_rd0",  dout_d[0], 0);

    // same-address dual write: port 0 wins
    wen = 2'b11; wr_addr[0] = 4'd3; wr_addr[1] = 4'd3;
    d_in[0] = 16'h00AA; d_in[1] = 16'h00BB; rd_addr[0] = 4'd3; #1;
    chk("conf_byp",      dout_a[0], 16'h00AA);
    chk("conf_nbyp_old", dout_b[0], 30);
    tick();
    wen = 2'b00; #1;
    chk("conf_pulse",   conf_a,    1);
    chk("conf_pulse_d", conf_d,    1);
    chk("conf_mem",     dout_a[0], 16'h00AA);
    chk("conf_lat",     dout_c[0], 16'h00AA);
    tick();
    chk("conf_clr",     conf_a,    0);

    // independent dual write with same-cycle reads on both ports
    wen = 2'b11; wr_addr[0] = 4'd7; d_in[0] = 16'h0055;
    wr_addr[1] = 4'd4; d_in[1] = 16'h0044;
    rd_addr[0] = 4'd7; rd_addr[1] = 4'd4; #1;
    chk("byp_p0",      dout_a[0], 16'h0055);
    chk("byp_p1",      dout_a[1], 16'h0044);
    chk("nbyp_old_p0", dout_b[0], 70);
    chk("nbyp_old_p1", dout_b[1], 40);
    tick();
    wen = 2'b00; #1;
    chk("nbyp_new_p0", dout_b[0], 16'h0055);
    chk("nbyp_new_p1", dout_b[1], 16'h0044);
    chk("no_conf",     conf_a,    0);

    // registered read latency
    wen = 2'b01; wr_addr[0] = 4'd2; d_in[0] = 16'h0012;
    rd_addr[0] = 4'd9; rd_addr[1] = 4'd0;
    tick();
    wen = 2'b00; rd_addr[0] = 4'd2; #1;
    chk("lat_hold", dout_c[0], 90);
    tick();
    chk("lat_one",  dout_c[0], 16'h0012);

    // out-of-range write on the 12-entry variant
    wen = 2'b01; wr_addr[0] = 4'd13; d_in[0] = 16'h0077; rd_addr[0] = 4'd13; #1;
    chk("oor_rd13", dout_d[0], 0);
    tick();
    wen = 2'b00; rd_addr[0] = 4'd5; rd_addr[1] = 4'd1; #1;
    chk("oor_wr_err",  aerr_d,    1);
    chk("valid_noerr", aerr_a,    0);
    chk("oor_mem5",    dout_d[0], 0);
    chk("oor_mem1",    dout_d[1], 0);
    tick();
    chk("oor_wr_clr",  aerr_d,    0);

    // async reset out of RUN
    rd_addr[0] = 4'd2; rd_addr[1] = 4'd0;
    tick();
    chk("pre_rst_lat", dout_c[0], 16'h0012);
    rst_n = 1'b0; #1;
    chk("arst_dout_reg", dout_c[0], 0);
    chk("arst_ready",    rdy_a,     0);
    chk("arst_ready_d",  rdy_d,     0);

    // reset again in the middle of the sweep
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("mid_init_notready", rdy_a, 0);
    rst_n = 1'b0; #1;
    chk("mid_init_rst", rdy_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    wait_ready(1'b0, na, nd);
    chk("rerun_lat16", na, 16);
    for (int i = 0; i < 8; i++) begin
      rd_addr[0] = AW'(i); rd_addr[1] = AW'(i + 8); #1;
      chk("sweep_lo", dout_a[0], i * 10);
      chk("sweep_hi", dout_a[1], (i + 8) * 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
